// File: rtl/pwm_pkg.sv
// pwm_pkg: definitions shared by the PWM generator and capture blocks.
//   DUTY_W / DUTY_MAX : width and largest value of the 4-bit duty code
//   state_t           : capture FSM states
package pwm_pkg;

  localparam int DUTY_W = 4;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 4'd15;

  typedef enum logic [1:0] {
    WAIT_EDGE,
    HIGH,
    LOW
  } state_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync: brings the asynchronous PWM line into the clk domain and
// flags its edges.
//   clk, rst : system clock, synchronous active-high reset
//   pwm_in   : raw asynchronous PWM input
//   s        : synchronized line level (last synchronizer stage)
//   rise     : s is high this cycle and was low the cycle before
//   fall     : s is low this cycle and was high the cycle before
module pwm_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   s_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      s_d   <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pwm_in};
      s_d   <= chain[SYNC_STAGES-1];
    end
  end

  assign s    = chain[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM waveform frame by frame (rise to
// rise) and recovers its 4-bit duty code.
//   clk, rst   : system clock, synchronous active-high reset
//   pwm_in     : asynchronous PWM input
//   duty       : last recovered duty code
//   valid      : one-cycle pulse whenever duty is updated
//   locked     : two consecutive good frames carried the same code
//   err_period : one-cycle pulse, frame length outside PERIOD +/- TOL
//   stuck      : no rising edge for 2*PERIOD cycles
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int PERIOD      = 160,
  parameter int STEP        = 10,
  parameter int TOL         = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty,
  output logic              valid,
  output logic              locked,
  output logic              err_period,
  output logic              stuck
);

  localparam int FCNT_W = $clog2(2*PERIOD+1);
  localparam int PRE_W  = $clog2(STEP+1);

  localparam logic [FCNT_W-1:0] TMO      = FCNT_W'(2*PERIOD);
  localparam logic [FCNT_W-1:0] P_LO     = FCNT_W'(PERIOD-TOL);
  localparam logic [FCNT_W-1:0] P_HI     = FCNT_W'(PERIOD+TOL);
  localparam logic [PRE_W-1:0]  PRE_INIT = PRE_W'(STEP/2);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(STEP-1);
  localparam logic [4:0]        STEP_SAT = 5'd16;

  // step_cnt may reach 16 (high time >= 15.5 steps); the code tops out at 15
  function automatic logic [DUTY_W-1:0] sat_code(input logic [4:0] steps);
    return (steps > 5'(DUTY_MAX)) ? DUTY_MAX : steps[DUTY_W-1:0];
  endfunction

  logic s, rise, fall;

  pwm_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .pwm_in(pwm_in),
    .s     (s),
    .rise  (rise),
    .fall  (fall)
  );

  state_t              state, state_n;
  logic [FCNT_W-1:0]   frame_cnt;
  logic [PRE_W-1:0]    presc;
  logic [4:0]          step_cnt;
  logic [DUTY_W-1:0]   prev_code;
  logic                have_prev;

  logic                start;
  logic                frame_end;
  logic                timeout;
  logic                period_ok;
  logic [DUTY_W-1:0]   code;

  assign period_ok = (frame_cnt >= P_LO) && (frame_cnt <= P_HI);
  assign code      = sat_code(step_cnt);

  // A rise in LOW both closes the old frame and opens the next one, so a
  // rise always beats a timeout landing on the same cycle.
  always_comb begin
    state_n   = state;
    start     = 1'b0;
    frame_end = 1'b0;
    timeout   = 1'b0;
    case (state)
      WAIT_EDGE: begin
        if (rise) begin
          start   = 1'b1;
          state_n = HIGH;
        end
      end
      HIGH: begin
        if (frame_cnt >= TMO) begin
          timeout = 1'b1;
          state_n = WAIT_EDGE;
        end else if (fall) begin
          state_n = LOW;
        end
      end
      LOW: begin
        if (rise) begin
          frame_end = 1'b1;
          start     = 1'b1;
          state_n   = HIGH;
        end else if (frame_cnt >= TMO) begin
          timeout = 1'b1;
          state_n = WAIT_EDGE;
        end
      end
      default: state_n = WAIT_EDGE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_EDGE;
      frame_cnt  <= '0;
      presc      <= '0;
      step_cnt   <= '0;
      prev_code  <= '0;
      have_prev  <= 1'b0;
      duty       <= '0;
      valid      <= 1'b0;
      locked     <= 1'b0;
      err_period <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      state      <= state_n;
      valid      <= 1'b0;
      err_period <= 1'b0;

      // Counters: the rise cycle counts as frame cycle 1; the prescaler is
      // preloaded with STEP/2 so the step count rounds to nearest.
      if (start) begin
        frame_cnt <= FCNT_W'(1);
        presc     <= PRE_INIT;
        step_cnt  <= '0;
      end else if (state == HIGH) begin
        frame_cnt <= (frame_cnt == '1) ? frame_cnt : frame_cnt + FCNT_W'(1);
        if (presc == PRE_LAST) begin
          presc    <= '0;
          step_cnt <= (step_cnt == STEP_SAT) ? step_cnt : step_cnt + 5'd1;
        end else begin
          presc <= presc + PRE_W'(1);
        end
      end else if (state == LOW) begin
        frame_cnt <= (frame_cnt == '1) ? frame_cnt : frame_cnt + FCNT_W'(1);
      end

      // Frame evaluation: lock compares against the previous good frame only
      if (frame_end) begin
        if (period_ok) begin
          duty      <= code;
          valid     <= 1'b1;
          stuck     <= 1'b0;
          locked    <= have_prev && (code == prev_code);
          prev_code <= code;
          have_prev <= 1'b1;
        end else begin
          err_period <= 1'b1;
          locked     <= 1'b0;
          have_prev  <= 1'b0;
        end
      end

      if (timeout) begin
        stuck     <= 1'b1;
        locked    <= 1'b0;
        valid     <= 1'b1;
        duty      <= s ? DUTY_MAX : '0;
        have_prev <= 1'b0;
      end
    end
  end

endmodule
